bldc_bank_sequencer: RTL

//  Sequencer for the robot's bank of BLDC drivers (4 drive motors + dribbler).

---
 rtl/bldc_bank_sequencer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bldc_bank_sequencer.sv
// bldc_bank_sequencer
//   Command sequencer for a bank of BLDC drivers (drive motors plus dribbler).
//   Commands are staged per channel and committed together. Each channel's duty
//   is slew-limited. Startups are staggered so that only one motor starts per
//   window. Driver faults are retried with a backoff period, and a channel
//   latches DEAD after RETRY_LIMIT faults. A command watchdog stops every motor
//   when commits stop arriving.
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   cmd_valid_i/ready_o  staging write handshake (cmd_motor_i, cmd_duty_i, cmd_dir_i)
//   cmd_commit_i         copy all staged values (incl. a same-cycle write) to targets
//   clear_faults_i       release DEAD channels and zero all retry counts
//   drv_fault_i          per-driver fault
//   drv_connected_i      per-driver hall connected
//   drv_en_o             per-driver enable
//   drv_duty_o           per-driver duty; channel i is at [i*DUTY_WIDTH +: DUTY_WIDTH]
//   drv_dir_o            per-driver direction
//   motor_fault_o        channel latched DEAD
//   wdt_expired_o        sticky watchdog-stop flag, cleared by a commit
module bldc_bank_sequencer #(
    parameter int NUM_MOTORS     = 5,
    parameter int DUTY_WIDTH     = 9,
    parameter int SLEW_DIV       = 32,
    parameter int STAGGER_CYCLES = 256,
    parameter int BACKOFF_CYCLES = 4096,
    parameter int RETRY_LIMIT    = 3,
    parameter int WDT_CYCLES     = 1 << 20
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic [2:0]                       cmd_motor_i,
    input  logic [DUTY_WIDTH-1:0]            cmd_duty_i,
    input  logic                             cmd_dir_i,
    input  logic                             cmd_commit_i,
    input  logic                             clear_faults_i,
    input  logic [NUM_MOTORS-1:0]            drv_fault_i,
    input  logic [NUM_MOTORS-1:0]            drv_connected_i,
    output logic [NUM_MOTORS-1:0]            drv_en_o,
    output logic [NUM_MOTORS*DUTY_WIDTH-1:0] drv_duty_o,
    output logic [NUM_MOTORS-1:0]            drv_dir_o,
    output logic [NUM_MOTORS-1:0]            motor_fault_o,
    output logic                             wdt_expired_o
);
    localparam int PW = $clog2(SLEW_DIV + 1);
    localparam int SW = $clog2(STAGGER_CYCLES + 1);
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);
    localparam int RW = $clog2(RETRY_LIMIT + 1);
    localparam int WW = $clog2(WDT_CYCLES + 1);
    localparam int GW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;

    localparam logic [PW-1:0] PRESC_LAST   = PW'(SLEW_DIV - 1);
    // The grant cycle itself counts as one cycle of the window, so grants land
    // exactly STAGGER_CYCLES apart.
    localparam logic [SW-1:0] STAGGER_LOAD = SW'(STAGGER_CYCLES - 1);
    localparam logic [BW-1:0] BACKOFF_LOAD = BW'(BACKOFF_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(RETRY_LIMIT - 1);
    localparam logic [WW-1:0] WDT_MAX      = WW'(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_LAST     = WW'(WDT_CYCLES - 1);

    typedef enum logic [2:0] {S_OFF, S_WAIT, S_ACTIVE, S_BACKOFF, S_DEAD} state_e;

    logic                  cmd_ready_q;
    logic                  wdt_expired_q;
    logic [WW-1:0]         wdt_cnt_q;
    logic [PW-1:0]         presc_q;
    logic [SW-1:0]         stagger_q;
    logic [GW-1:0]         last_grant_q;
    logic                  slew_tick;
    logic                  cmd_write;
    logic [NUM_MOTORS-1:0] slot_req;
    logic [NUM_MOTORS-1:0] grant;
    logic                  grant_any;
    logic [GW-1:0]         grant_idx;
    logic [GW-1:0]         scan_idx;

    assign slew_tick     = (presc_q == PRESC_LAST);
    assign cmd_write     = cmd_valid_i & cmd_ready_q;
    assign cmd_ready_o   = cmd_ready_q;
    assign wdt_expired_o = wdt_expired_q;

    // Round-robin arbiter: scan starts at the channel after the last grant.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = last_grant_q;
        scan_idx  = '0;
        if (stagger_q == '0) begin
            for (int k = 1; k <= NUM_MOTORS; k++) begin
                scan_idx = GW'((int'(last_grant_q) + k) % NUM_MOTORS);
                if (!grant_any && slot_req[scan_idx]) begin
                    grant_any       = 1'b1;
                    grant[scan_idx] = 1'b1;
                    grant_idx       = scan_idx;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cmd_ready_q   <= 1'b0;
            wdt_expired_q <= 1'b0;
            wdt_cnt_q     <= '0;
            presc_q       <= '0;
            stagger_q     <= '0;
            last_grant_q  <= GW'(NUM_MOTORS - 1);
        end else begin
            cmd_ready_q <= 1'b1;
            presc_q     <= slew_tick ? '0 : presc_q + 1'b1;
            if (grant_any) begin
                stagger_q    <= STAGGER_LOAD;
                last_grant_q <= grant_idx;
            end else if (stagger_q != '0) begin
                stagger_q <= stagger_q - 1'b1;
            end
            if (cmd_commit_i) begin
                wdt_cnt_q     <= '0;
                wdt_expired_q <= 1'b0;
            end else if (wdt_cnt_q != WDT_MAX) begin
                wdt_cnt_q <= wdt_cnt_q + 1'b1;
                if (wdt_cnt_q == WDT_LAST) begin
                    wdt_expired_q <= 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_ch
        state_e                state_q, state_d;
        logic [DUTY_WIDTH-1:0] stage_duty_q, stage_duty_d, target_duty_q, eff_target;
        logic [DUTY_WIDTH-1:0] duty_q, duty_d;
        logic                  stage_dir_q, stage_dir_d, target_dir_q, dir_q, dir_d;
        logic [RW-1:0]         retry_q, retry_d;
        logic [BW-1:0]         backoff_q, backoff_d;
        logic                  wr_hit, en_c, fault_c;

        // Indices >= NUM_MOTORS never hit a channel, so such writes are dropped.
        assign wr_hit       = cmd_write && (cmd_motor_i == 3'(gi));
        assign stage_duty_d = wr_hit ? cmd_duty_i : stage_duty_q;
        assign stage_dir_d  = wr_hit ? cmd_dir_i : stage_dir_q;
        assign eff_target   = wdt_expired_q ? '0 : target_duty_q;
        assign slot_req[gi] = (state_q == S_WAIT) && (eff_target != '0) && drv_connected_i[gi];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state_q       <= S_OFF;
                stage_duty_q  <= '0;
                stage_dir_q   <= 1'b0;
                target_duty_q <= '0;
                target_dir_q  <= 1'b0;
                duty_q        <= '0;
                dir_q         <= 1'b0;
                retry_q       <= '0;
                backoff_q     <= '0;
            end else begin
                state_q      <= state_d;
                stage_duty_q <= stage_duty_d;
                stage_dir_q  <= stage_dir_d;
                duty_q       <= duty_d;
                dir_q        <= dir_d;
                retry_q      <= retry_d;
                backoff_q    <= backoff_d;
                if (cmd_commit_i) begin
                    target_duty_q <= stage_duty_d;
                    target_dir_q  <= stage_dir_d;
                end
            end
        end

        always_comb begin
            state_d   = state_q;
            duty_d    = duty_q;
            dir_d     = dir_q;
            retry_d   = retry_q;
            backoff_d = backoff_q;
            case (state_q)
                S_OFF: begin
                    duty_d = '0;
                    if (eff_target != '0 && drv_connected_i[gi]) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (eff_target == '0 || !drv_connected_i[gi]) begin
                        state_d = S_OFF;
                    end else if (grant[gi]) begin
                        // Duty is zero here, so the direction can be taken directly.
                        state_d = S_ACTIVE;
                        duty_d  = '0;
                        dir_d   = target_dir_q;
                    end
                end
                S_ACTIVE: begin
                    if (drv_fault_i[gi]) begin
                        duty_d  = '0;
                        retry_d = retry_q + 1'b1;
                        if (retry_q == RETRY_LAST) begin
                            state_d = S_DEAD;
                        end else begin
                            state_d   = S_BACKOFF;
                            backoff_d = BACKOFF_LOAD;
                        end
                    end else if (!drv_connected_i[gi]) begin
                        state_d = S_OFF;
                        duty_d  = '0;
                    end else if (eff_target == '0 && duty_q == '0) begin
                        state_d = S_OFF;
                        retry_d = '0;
                    end else if (slew_tick) begin
                        if (dir_q != target_dir_q) begin
                            // Reverse: ramp down; flip on the step that reaches zero.
                            if (duty_q[DUTY_WIDTH-1:1] != '0) begin
                                duty_d = duty_q - 1'b1;
                            end else begin
                                duty_d = '0;
                                dir_d  = target_dir_q;
                            end
                        end else if (duty_q < eff_target) begin
                            duty_d = duty_q + 1'b1;
                        end else if (duty_q > eff_target) begin
                            duty_d = duty_q - 1'b1;
                        end
                    end
                end
                S_BACKOFF: begin
                    duty_d = '0;
                    if (backoff_q == '0) state_d = S_OFF;
                    else backoff_d = backoff_q - 1'b1;
                end
                S_DEAD: begin
                    duty_d = '0;
                    if (clear_faults_i) state_d = S_OFF;
                end
                default: state_d = S_OFF;
            endcase
            if (clear_faults_i) retry_d = '0;
        end

        always_comb begin
            en_c    = 1'b0;
            fault_c = 1'b0;
            case (state_q)
                S_ACTIVE: en_c    = 1'b1;
                S_DEAD:   fault_c = 1'b1;
                default:  ;
            endcase
        end

        assign drv_en_o[gi]                            = en_c;
        assign motor_fault_o[gi]                       = fault_c;
        assign drv_duty_o[gi*DUTY_WIDTH +: DUTY_WIDTH] = duty_q;
        assign drv_dir_o[gi]                           = dir_q;
    end

endmodule
